phi_lut_pipe: RTL and testbench



---
 rtl/phi_lut_pipe_pkg.sv | 23 ++
 rtl/phi_lut_pipe_if.sv | 28 ++
 rtl/phi_lut_pipe_table.sv | 39 +++
 rtl/phi_lut_pipe.sv | 107 ++++++++++
 tb/tb_phi_lut_pipe.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/phi_lut_pipe_pkg.sv
// Shared constants for the phi lookup pipeline: the power-on phi table
// (magnitude step 0.25 in, 2 fractional bits out).
package phi_pkg;

   localparam int PHI_DEFAULT_DEPTH = 32;

   localparam logic [3:0] PHI_DEFAULT [PHI_DEFAULT_DEPTH] = '{
      4'd15, 4'd8, 4'd6, 4'd4, 4'd3, 4'd2, 4'd2, 4'd1,
      4'd1,  4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
      4'd0,  4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0
   };

   // Default contents for any table depth; entries past the constant are zero.
   function automatic logic [3:0] phi_default_entry(input int i);
      logic [4:0] idx;
      idx = i[4:0];
      if (i >= 0 && i < PHI_DEFAULT_DEPTH)
         return PHI_DEFAULT[idx];
      return 4'd0;
   endfunction

endpackage

// File: rtl/phi_lut_pipe_if.sv
// Stream-in / stream-out / table-config bundle for phi_lut_pipe.
// slave is the unit's view, master is the upstream/downstream/config view.
interface phi_lut_pipe_if #(
   parameter int LANES  = 4,
   parameter int X_W    = 7,
   parameter int Y_W    = 4,
   parameter int ADDR_W = 5
);
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*X_W-1:0]   x_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*Y_W-1:0]   y_out;
   logic                   cfg_we;
   logic [ADDR_W-1:0]      cfg_addr;
   logic [Y_W-1:0]         cfg_data;

   modport master (
      output in_valid, x_in, out_ready, cfg_we, cfg_addr, cfg_data,
      input  in_ready, out_valid, y_out
   );

   modport slave (
      input  in_valid, x_in, out_ready, cfg_we, cfg_addr, cfg_data,
      output in_ready, out_valid, y_out
   );
endinterface

// File: rtl/phi_lut_pipe_table.sv
// Reprogrammable phi table: flop array reloaded with the default curve on
// reset, one write port, LANES combinational read ports.
module phi_table
   import phi_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int Y_W    = 4,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [Y_W-1:0]          wdata,
   input  logic [LANES*ADDR_W-1:0] raddr,
   output logic [LANES*Y_W-1:0]    rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [Y_W-1:0] mem_reg [DEPTH];

   // Reset has priority, so a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_reg[i] <= Y_W'(phi_default_entry(i));
      end else if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
         assign rdata[gi*Y_W +: Y_W] = mem_reg[raddr[gi*ADDR_W +: ADDR_W]];
      end
   endgenerate

endmodule

// File: rtl/phi_lut_pipe.sv
// Two-stage multi-lane phi lookup (clamp+index, table read) with full
// valid/ready backpressure. Optional clamp counter behind PHI_SAT_CNT_EN.
module phi_lut_pipe
   import phi_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int X_W    = 7,
   parameter int Y_W    = 4,
   parameter int ADDR_W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   phi_lut_pipe_if.slave bus
`ifdef PHI_SAT_CNT_EN
   ,
   output logic [15:0]  sat_cnt
`endif
);

   localparam int DEPTH = 1 << ADDR_W;

   logic                    s1_valid_reg;
   logic                    s2_valid_reg;
   logic                    s1_adv;
   logic                    s2_adv;
   logic [LANES-1:0]        sat_lane;
   logic [LANES*ADDR_W-1:0] idx_next;
   logic [LANES*ADDR_W-1:0] s1_idx_reg;
   logic [LANES*Y_W-1:0]    rd_data;
   logic [LANES*Y_W-1:0]    s2_data_reg;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_clamp
         logic [X_W-1:0] x_lane;
         assign x_lane       = bus.x_in[gi*X_W +: X_W];
         assign sat_lane[gi] = (32'(x_lane) >= 32'(DEPTH));
         assign idx_next[gi*ADDR_W +: ADDR_W] =
            sat_lane[gi] ? {ADDR_W{1'b1}} : ADDR_W'(x_lane);
      end
   endgenerate

   // A stage may advance when it is empty or the stage after it is moving.
   assign s2_adv       = !s2_valid_reg || bus.out_ready;
   assign s1_adv       = !s1_valid_reg || s2_adv;
   assign bus.in_ready = s1_adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s1_idx_reg   <= '0;
         s2_data_reg  <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid)
               s1_idx_reg <= idx_next;
         end
         if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg)
               s2_data_reg <= rd_data;
         end
      end
   end

   assign bus.out_valid = s2_valid_reg;
   assign bus.y_out     = s2_data_reg;

   phi_table #(
      .LANES  (LANES),
      .Y_W    (Y_W),
      .ADDR_W (ADDR_W)
   ) u_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bus.cfg_we),
      .waddr (bus.cfg_addr),
      .wdata (bus.cfg_data),
      .raddr (s1_idx_reg),
      .rdata (rd_data)
   );

`ifdef PHI_SAT_CNT_EN
   logic        accept;
   logic [15:0] sat_cnt_reg;
   logic [16:0] sat_sum;

   assign accept = bus.in_valid && s1_adv;

   always_comb begin
      sat_sum = {1'b0, sat_cnt_reg};
      for (int i = 0; i < LANES; i++)
         sat_sum = sat_sum + 17'(sat_lane[i]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         sat_cnt_reg <= 16'd0;
      else if (accept)
         sat_cnt_reg <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
   end

   assign sat_cnt = sat_cnt_reg;
`endif

endmodule

// File: tb/tb_phi_lut_pipe.sv
// Directed + random bench for phi_lut_pipe with an in-order scoreboard.
module tb_phi_lut_pipe;

   localparam int LANES  = 4;
   localparam int X_W    = 7;
   localparam int Y_W    = 4;
   localparam int ADDR_W = 5;

   logic clk;
   logic rst_n;

   phi_lut_pipe_if #(.LANES(LANES), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) bus ();

`ifdef PHI_SAT_CNT_EN
   logic [15:0] sat_cnt;
`endif

   phi_lut_pipe #(.LANES(LANES), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus)
`ifdef PHI_SAT_CNT_EN
      ,
      .sat_cnt (sat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          chk_cnt   = 0;
   int          pass_cnt  = 0;
   int          push_cnt  = 0;
   int          pop_cnt   = 0;
   int          sat_model = 0;
   logic [15:0] exp_q [$];
   logic [3:0]  tbl [32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic tbl_default();
      int dflt [12] = '{15, 8, 6, 4, 3, 2, 2, 1, 1, 1, 1, 1};
      for (int i = 0; i < 32; i++)
         tbl[i] = (i < 12) ? 4'(dflt[i]) : 4'd0;
   endtask

   function automatic logic [27:0] pack(input int a, input int b, input int c, input int d);
      return {7'(d), 7'(c), 7'(b), 7'(a)};
   endfunction

   function automatic logic [15:0] model(input logic [27:0] x);
      logic [15:0] y;
      int          v;
      y = '0;
      for (int l = 0; l < 4; l++) begin
         v = int'(x[l*7 +: 7]);
         if (v >= 32) v = 31;
         y[l*4 +: 4] = tbl[v];
      end
      return y;
   endfunction

   function automatic int nsat(input logic [27:0] x);
      int n = 0;
      for (int l = 0; l < 4; l++)
         if (x[l*7 +: 7] >= 7'd32) n++;
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Handshakes are decided by the values standing at the falling edge.
   always @(negedge clk) begin
      logic [15:0] exp_y;
      if (rst_n === 1'b1) begin
         if (bus.out_valid && bus.out_ready) begin
            chk("sb_beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_y = exp_q.pop_front();
               chk($sformatf("sb_beat%0d", pop_cnt), 32'(bus.y_out), 32'(exp_y));
               pop_cnt++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.x_in));
            push_cnt++;
            sat_model += nsat(bus.x_in);
         end
      end
   end

   initial begin
      int          base_push;
      int          base_pop;
      int          sent;
      logic [15:0] hold;
`ifdef PHI_SAT_CNT_EN
      logic [15:0] sat0;
`endif

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.x_in      = '0;
      bus.out_ready = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
      tbl_default();
      repeat (2) step();
      rst_n = 1'b1;
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_y_out", 32'(bus.y_out), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PHI_SAT_CNT_EN
      chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
      step();

      // Latency: one beat, result exactly two cycles after acceptance.
      bus.x_in     = pack(0, 1, 4, 12);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      chk("lat_cycle1_out_valid", 32'(bus.out_valid), 32'd0);
      step();
      chk("lat_cycle2_out_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_y", 32'(bus.y_out), 32'h038F);
      step();

      // Clamp: indices past the table saturate to the last entry.
`ifdef PHI_SAT_CNT_EN
      sat0 = sat_cnt;
`endif
      bus.x_in     = pack(31, 32, 100, 127);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
`ifdef PHI_SAT_CNT_EN
      chk("clamp_sat_delta", 32'(16'(sat_cnt - sat0)), 32'd3);
`endif
      step();
      chk("clamp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("clamp_y", 32'(bus.y_out), 32'h0000);
      step();

      // Backpressure: six beats, downstream stalled in cycles 3..7.
      base_push = push_cnt;
      base_pop  = pop_cnt;
      hold      = '0;
      for (int c = 0; c < 60; c++) begin
         sent          = push_cnt - base_push;
         bus.out_ready = !(c >= 3 && c <= 7);
         bus.in_valid  = (sent < 6);
         bus.x_in      = pack(sent * 3, sent * 7 + 1, sent * 11 + 2, 40 + sent * 13);
         #1;
         if (c == 3) begin
            chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid_stall", 32'(bus.out_valid), 32'd1);
            hold = bus.y_out;
         end else if (c > 3 && c <= 7) begin
            chk($sformatf("bp_hold_y_c%0d", c), 32'(bus.y_out), 32'(hold));
            chk($sformatf("bp_in_ready_c%0d", c), 32'(bus.in_ready), 32'd0);
         end
         if (c > 8 && (push_cnt - base_push) == 6 && (pop_cnt - base_pop) == 6)
            break;
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_beats_sent", 32'(push_cnt - base_push), 32'd6);
      chk("bp_beats_recv", 32'(pop_cnt - base_pop), 32'd6);
      step();

      // Config write lands as beat A enters stage 2: A keeps 6, B sees 5.
      bus.x_in     = pack(2, 2, 2, 2);
      bus.in_valid = 1'b1;
      step();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 5'd2;
      bus.cfg_data = 4'd5;
      tbl[2]       = 4'd5;
      step();
      bus.cfg_we   = 1'b0;
      bus.in_valid = 1'b0;
      chk("cfg_old_out_valid", 32'(bus.out_valid), 32'd1);
      chk("cfg_old_y", 32'(bus.y_out), 32'h6666);
      step();
      chk("cfg_new_y", 32'(bus.y_out), 32'h5555);
      step();

      // Reset with two beats in flight.
      bus.x_in     = pack(2, 3, 40, 0);
      bus.in_valid = 1'b1;
      step();
      bus.x_in = pack(1, 2, 2, 2);
      step();
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      step();
      rst_n = 1'b1;
      exp_q.delete();
      tbl_default();
      sat_model = 0;
      chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_y_out", 32'(bus.y_out), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PHI_SAT_CNT_EN
      chk("mid_rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
      repeat (4) step();
      bus.x_in     = pack(2, 2, 2, 2);
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      chk("revert_out_valid", 32'(bus.out_valid), 32'd1);
      chk("revert_y", 32'(bus.y_out), 32'h6666);
      step();

      // Random stream with random downstream readiness.
      base_push = push_cnt;
      base_pop  = pop_cnt;
      for (int c = 0; c < 3000; c++) begin
         sent = push_cnt - base_push;
         if (sent == 100 && (pop_cnt - base_pop) == 100)
            break;
         bus.in_valid  = (sent < 100);
         bus.x_in      = 28'($urandom);
         bus.out_ready = ($urandom_range(0, 1) == 1);
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("rand_beats_sent", 32'(push_cnt - base_push), 32'd100);
      chk("rand_beats_recv", 32'(pop_cnt - base_pop), 32'd100);
      step();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef PHI_SAT_CNT_EN
      chk("sat_cnt_total", 32'(sat_cnt), 32'(sat_model));
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
